alu_and_bist: RTL
=================

Name: alu_and_bist

Overview:
Built-in self-test sequencer for the bitwise AND unit of the integer ALU. It drives every operand combination into the AND unit, samples the unit's result, and compares it against an internal reference. It counts mismatches and records the first failing operand pair. It sits beside the ALU operand muxes and is used in bring-up and regression.

Parameters:
WIDTH, 4, operand/result width of the AND unit under test
ERR_W, 8, width of the saturating mismatch counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
start  input  1  begin a test run; sampled only in IDLE or DONE
dut_a  output  WIDTH  operand A to the AND unit (registered)
dut_b  output  WIDTH  operand B to the AND unit (registered)
dut_y  input  WIDTH  result from the AND unit (combinational path, settles within one cycle)
busy  output  1  high while in SETTLE or CHECK
done  output  1  high while in DONE
pass  output  1  high in DONE when err_count==0; low otherwise
err_count  output  ERR_W  mismatch count, saturating at all-ones
fail_a  output  WIDTH  dut_a of first mismatching vector
fail_b  output  WIDTH  dut_b of first mismatching vector
fail_valid  output  1  high once fail_a/fail_b hold a captured vector

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0, fail_valid=0. Reset overrides start.
- Vector counter: internal vec of 2*WIDTH bits, {dut_a,dut_b}=vec. dut_a is the high half.
- Vector order: ascending from 0 to 2^(2*WIDTH)-1.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: if start, then vec<=0, dut_a/dut_b<=0, err_count<=0, fail_valid<=0, fail_a/fail_b<=0, next SETTLE.
- SETTLE: one cycle with operands held stable. Next CHECK.
- CHECK: expected = dut_a & dut_b, computed internally.
  - Mismatch when dut_y != expected.
  - On mismatch, err_count increments unless already all-ones.
  - On the first mismatch of a run (fail_valid==0), capture fail_a<=dut_a, fail_b<=dut_b, fail_valid<=1.
  - If vec is all-ones, next DONE. Otherwise vec<=vec+1, drive the new operands, next SETTLE.
- DONE: done=1, pass=(err_count==0) with the final count included. Outputs hold.
  - start in DONE restarts exactly as from IDLE.
  - Without start, stay in DONE indefinitely.
- start while busy is ignored; the run is not restarted or perturbed.
- Latency: 2 cycles per vector.
  - For WIDTH=4: 256 vectors, done rises 512 cycles after the edge that samples start.
  - Generally the latency is 2^(2*WIDTH+1) cycles.
- Counter wrap-around: vec never wraps, since the all-ones check exits to DONE.
- Saturation: err_count sticks at 2^ERR_W-1. pass stays 0.
- Reset mid-run: next edge returns to IDLE with all reset values. No partial result is retained.
- pass and done are 0 in all states except DONE.

Test Plan:
- Correct gate (dut_y=dut_a&dut_b), pulse start:
  - busy high from the next cycle.
  - done=1 and pass=1 exactly 512 cycles after start.
  - err_count=0, fail_valid=0.
- Stuck-at-0 on bit 0 (dut_y=(a&b)&4'b1110):
  - done with pass=0, err_count=64.
  - fail_valid=1, fail_a=4'b0001, fail_b=4'b0001.
- Inverted output (dut_y=~(a&b)):
  - all 256 vectors mismatch, err_count saturates at 255, pass=0.
  - fail_a=0, fail_b=0, fail_valid=1.
- Inverted output with ERR_W=4: err_count=15 at done, no wrap to 0.
- Assert rst for one cycle at cycle 100 of a run:
  - next cycle state IDLE, all outputs at reset values.
  - a new start then completes normally with pass=1.
- start pulsed repeatedly while busy: ignored, and done still at cycle 512.
- start in DONE: clears err_count/fail_valid, and a second full run completes with identical results.

Source files
------------

// File: rtl/alu_and_bist.sv
// BIST sequencer for the ALU bitwise-AND unit: sweeps every operand pair, checks
// the unit's result against a local AND, counts mismatches and keeps the first failure.
module alu_and_bist #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   vec, vec_nxt;
    logic [ERR_W-1:0]     err_nxt;
    logic [WIDTH-1:0]     fail_a_nxt, fail_b_nxt;
    logic                 fail_valid_nxt;
    logic                 mismatch;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Operands come straight from the registered vector counter
    assign dut_a    = vec[2*WIDTH-1:WIDTH];
    assign dut_b    = vec[WIDTH-1:0];
    assign mismatch = (dut_y != (dut_a & dut_b));

    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        err_nxt        = err_count;
        fail_a_nxt     = fail_a;
        fail_b_nxt     = fail_b;
        fail_valid_nxt = fail_valid;
        busy           = 1'b0;
        done           = 1'b0;
        pass           = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    done = 1'b1;
                    pass = (err_count == '0);
                end
                if (start) begin
                    state_nxt      = SETTLE;
                    vec_nxt        = '0;
                    err_nxt        = '0;
                    fail_a_nxt     = '0;
                    fail_b_nxt     = '0;
                    fail_valid_nxt = 1'b0;
                end
            end
            SETTLE: begin
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (mismatch) begin
                    err_nxt = sat_inc(err_count);
                    if (!fail_valid) begin
                        fail_a_nxt     = dut_a;
                        fail_b_nxt     = dut_b;
                        fail_valid_nxt = 1'b1;
                    end
                end
                // The all-ones vector ends the sweep, so vec never wraps
                if (&vec) begin
                    state_nxt = DONE;
                end else begin
                    vec_nxt   = vec + 1'b1;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            err_count  <= err_nxt;
            fail_a     <= fail_a_nxt;
            fail_b     <= fail_b_nxt;
            fail_valid <= fail_valid_nxt;
        end
    end

endmodule
